serial_adder: RTL and testbench

- Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop processes WIDTH-bit operands LSB-first, one bit per clock.
- Successor to the combinational full adder cell: same a/b/cin arithmetic, generalised to WIDTH bits, with a subtract mode, signed-overflow flag and start/done handshake.
- Used where area matters more than latency (counters, accumulators, slow datapaths).

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side (the adder) returns results.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB-first, one bit per clock, with a start/done handshake.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             ovf_q;

   logic             s_bit;
   logic             carry_nxt;
   logic             last_bit;
   logic [WIDTH-1:0] res_shift;

   assign s_bit     = op_a_q[0] ^ op_b_q[0] ^ carry_q;
   assign carry_nxt = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
   assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
   // Shift form stays legal for WIDTH == 1, where a part-select would not.
   assign res_shift = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  op_a_q  <= bus.a;
                  op_b_q  <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub | bus.cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               op_a_q  <= op_a_q >> 1;
               op_b_q  <= op_b_q >> 1;
               carry_q <= carry_nxt;
               res_q   <= res_shift;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  // carry_q is the carry into the MSB on this bit
                  sum_q   <= res_shift;
                  cout_q  <= carry_nxt;
                  ovf_q   <= carry_q ^ carry_nxt;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder at WIDTH 1, 8 and 16,
// checked against an arithmetic reference model.
module tb_serial_adder;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   longint unsigned exp_sum [3];
   bit              exp_cout[3];
   bit              exp_ovf [3];

   serial_adder_if #(.WIDTH(1))  if1  ();
   serial_adder_if #(.WIDTH(8))  if8  ();
   serial_adder_if #(.WIDTH(16)) if16 ();

   serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
   serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
   serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int idx(input int w);
      return (w == 1) ? 0 : (w == 8) ? 1 : 2;
   endfunction

   // Reference: plain integer arithmetic; overflow from the signed range.
   function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                 input bit cin, input bit sub, output longint unsigned s,
                                 output bit co, output bit ov);
      longint unsigned mask;
      longint unsigned tot;
      longint          half;
      longint          sa;
      longint          sb;
      longint          st;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      a    = a & mask;
      b    = b & mask;
      tot  = sub ? (a + ((~b) & mask) + 1) : (a + b + longint'(cin));
      s    = tot & mask;
      co   = ((tot >> w) & 1) != 0;
      sa   = (a >= half) ? longint'(a) - 2 * half : longint'(a);
      sb   = (b >= half) ? longint'(b) - 2 * half : longint'(b);
      st   = sub ? sa - sb : sa + sb + longint'(cin);
      ov   = (st < -half) || (st > half - 1);
   endfunction

   task automatic drive(input int w, input logic st, input longint unsigned a,
                        input longint unsigned b, input logic cin, input logic sub);
      case (w)
         1: begin
            if1.start = st; if1.a = a[0:0]; if1.b = b[0:0]; if1.cin = cin; if1.sub = sub;
         end
         8: begin
            if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub;
         end
         default: begin
            if16.start = st; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub;
         end
      endcase
   endtask

   // {busy, done, cout, ovf}
   function automatic logic [3:0] get_flags(input int w);
      case (w)
         1:       return {if1.busy, if1.done, if1.cout, if1.ovf};
         8:       return {if8.busy, if8.done, if8.cout, if8.ovf};
         default: return {if16.busy, if16.done, if16.cout, if16.ovf};
      endcase
   endfunction

   function automatic logic [63:0] get_sum(input int w);
      case (w)
         1:       return 64'(if1.sum);
         8:       return 64'(if8.sum);
         default: return 64'(if16.sum);
      endcase
   endfunction

   function automatic bit held(input int w);
      logic [3:0] f;
      int         id;
      f  = get_flags(w);
      id = idx(w);
      return (get_sum(w) === 64'(exp_sum[id])) && (f[1] === exp_cout[id]) &&
             (f[0] === exp_ovf[id]);
   endfunction

   task automatic run_op(input int w, input longint unsigned a, input longint unsigned b,
                         input logic cin, input logic sub, input string tag);
      int              id;
      int              edges;
      int              busy_n;
      bit              stable;
      longint unsigned es;
      bit              ec;
      bit              eo;
      logic [3:0]      f;
      id = idx(w);
      model(w, a, b, cin, sub, es, ec, eo);
      @(negedge clk);
      drive(w, 1'b1, a, b, cin, sub);
      @(posedge clk);
      #1 drive(w, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      edges  = 0;
      busy_n = 0;
      stable = 1'b1;
      @(negedge clk);
      while (get_flags(w)[2] !== 1'b1 && edges < 4 * w + 8) begin
         if (get_flags(w)[3] === 1'b1) busy_n++;
         if (!held(w)) stable = 1'b0;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      f = get_flags(w);
      check({tag, " done"}, 64'(f[2]), 64'd1);
      check({tag, " latency"}, 64'(edges), 64'(w));
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(w));
      check({tag, " busy_at_done"}, 64'(f[3]), 64'd0);
      check({tag, " outputs_stable"}, 64'(stable), 64'd1);
      check({tag, " sum"}, get_sum(w), 64'(es));
      check({tag, " cout"}, 64'(f[1]), 64'(ec));
      check({tag, " ovf"}, 64'(f[0]), 64'(eo));
      exp_sum[id]  = es;
      exp_cout[id] = ec;
      exp_ovf[id]  = eo;
      @(posedge clk);
   endtask

   initial begin
      int         edges;
      bit         saw_done;
      logic [3:0] f;
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 3; i++) begin
         exp_sum[i] = 0; exp_cout[i] = 0; exp_ovf[i] = 0;
      end
      drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
      drive(8, 1'b1, 8'h5A, 8'h33, 1'b1, 1'b0);
      drive(16, 1'b0, 0, 0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset flags w8", 64'(get_flags(8)), 64'd0);
      check("reset sum w8", get_sum(8), 64'd0);
      check("reset flags w16", 64'(get_flags(16)), 64'd0);
      drive(8, 1'b0, 0, 0, 1'b0, 1'b0);
      rst = 1'b0;

      // Directed WIDTH=8 cases
      run_op(8, 'hFF, 'h01, 1'b0, 1'b0, "add_ff_01");
      run_op(8, 'h7F, 'h01, 1'b0, 1'b0, "add_7f_01");
      run_op(8, 'h80, 'h01, 1'b0, 1'b1, "sub_80_01");
      run_op(8, 'h05, 'h07, 1'b1, 1'b1, "sub_05_07");

      // Handshake: starts in RUN and DONE are ignored
      @(negedge clk);
      drive(8, 1'b1, 'h10, 'h20, 1'b0, 1'b0);
      @(posedge clk);
      #1 drive(8, 1'b0, 'h10, 'h20, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(8, 1'b1, 'hAA, 'h20, 1'b0, 1'b0);
      @(posedge clk);
      #1 drive(8, 1'b0, 'hAA, 'h20, 1'b0, 1'b0);
      edges = 3;
      @(negedge clk);
      while (get_flags(8)[2] !== 1'b1 && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("hs done", 64'(get_flags(8)[2]), 64'd1);
      check("hs latency", 64'(edges), 64'd8);
      check("hs sum", get_sum(8), 64'h30);
      check("hs cout", 64'(get_flags(8)[1]), 64'd0);
      drive(8, 1'b1, 'h11, 'h22, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("hs idle flags", 64'(get_flags(8)), 64'd0);
      check("hs idle sum", get_sum(8), 64'h30);
      @(posedge clk);
      #1 drive(8, 1'b0, 'h11, 'h22, 1'b0, 1'b0);
      @(negedge clk);
      check("hs held accept busy", 64'(get_flags(8)[3]), 64'd1);
      check("hs run sum", get_sum(8), 64'h30);
      edges = 0;
      while (get_flags(8)[2] !== 1'b1 && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("hs2 latency", 64'(edges), 64'd8);
      check("hs2 sum", get_sum(8), 64'h33);
      exp_sum[1] = 'h33; exp_cout[1] = 1'b0; exp_ovf[1] = 1'b0;
      @(posedge clk);

      // Reset in RUN cycle 3 aborts without a done pulse
      @(negedge clk);
      drive(8, 1'b1, 'hC3, 'h5A, 1'b1, 1'b0);
      @(posedge clk);
      #1 drive(8, 1'b0, 'hC3, 'h5A, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_run flags", 64'(get_flags(8)), 64'd0);
      check("rst_run sum", get_sum(8), 64'd0);
      for (int i = 0; i < 3; i++) begin
         exp_sum[i] = 0; exp_cout[i] = 0; exp_ovf[i] = 0;
      end
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         f = get_flags(8);
         if (f[2] !== 1'b0 || f[3] !== 1'b0) saw_done = 1'b1;
      end
      check("rst_run no_activity", 64'(saw_done), 64'd0);
      run_op(8, 'h3C, 'hA5, 1'b1, 1'b0, "after_rst");

      // WIDTH=1 exhaustive add
      for (int i = 0; i < 8; i++) begin
         run_op(1, longint'(i & 1), longint'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0, "w1");
      end

      // WIDTH=16 random mix
      for (int i = 0; i < 500; i++) begin
         run_op(16, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
                1'($urandom), 1'($urandom), "w16_rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
